// File: rtl/cpu_sequencer_if.sv
// Handshake bundle between the rv32i control sequencer and the memories, IR/decoder and PC.
// master: sequencer side; slave: datapath/memory side.
interface cpu_sequencer_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic [6:0]            opcode;
  logic                  imem_ready;
  logic                  dmem_ready;
  logic                  halt_req;
  logic                  imem_req;
  logic                  ir_load;
  logic                  dmem_req;
  logic                  dmem_we;
  logic                  reg_write_en;
  logic                  update_pc;
  logic                  pc_zero;
  logic                  halted;
  logic                  fault;
  logic [1:0]            fault_code;
  logic [DATA_WIDTH-1:0] instret;

  modport master (
    input  opcode, imem_ready, dmem_ready, halt_req,
    output imem_req, ir_load, dmem_req, dmem_we, reg_write_en, update_pc,
           pc_zero, halted, fault, fault_code, instret
  );

  modport slave (
    output opcode, imem_ready, dmem_ready, halt_req,
    input  imem_req, ir_load, dmem_req, dmem_we, reg_write_en, update_pc,
           pc_zero, halted, fault, fault_code, instret
  );
endinterface

// File: rtl/cpu_sequencer.sv
// Multi-cycle fetch/decode/execute/memory/writeback control FSM for the rv32i core,
// with memory wait timeouts, halt/fault handling and a retired-instruction counter.
module cpu_sequencer #(
  parameter int unsigned DATA_WIDTH  = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  cpu_sequencer_if.master bus
);

  localparam int unsigned CW = $clog2(MEM_TIMEOUT + 1);

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] FC_ILLEGAL = 2'd1;
  localparam logic [1:0] FC_IMEM_TO = 2'd2;
  localparam logic [1:0] FC_DMEM_TO = 2'd3;

  typedef enum logic [2:0] {
    S_BOOT, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_FAULT
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         wait_q, wait_d;
  logic [DATA_WIDTH-1:0] instret_q, instret_d;
  logic [1:0]            fault_code_q, fault_code_d;
  logic                  imem_req_q, imem_req_d;
  logic                  dmem_req_q, dmem_req_d;
  logic                  dmem_we_q, dmem_we_d;
  logic                  reg_write_en_q, reg_write_en_d;
  logic                  update_pc_q, update_pc_d;
  logic                  pc_zero_q, pc_zero_d;
  logic                  halted_q, halted_d;
  logic                  fault_q, fault_d;

  logic is_legal_c, is_ldst_c, is_store_c, writes_rd_c, boot_pulse_c;

  assign is_legal_c  = bus.opcode inside {OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH,
                                          OP_LOAD, OP_STORE, OP_IMM, OP_OP, OP_FENCE,
                                          OP_SYSTEM};
  assign is_store_c  = (bus.opcode == OP_STORE);
  assign is_ldst_c   = is_store_c || (bus.opcode == OP_LOAD);
  assign writes_rd_c = !(bus.opcode inside {OP_STORE, OP_BRANCH, OP_FENCE, OP_SYSTEM});

  // Next state, wait counter, retire counter and fault code.
  always_comb begin
    state_d      = state_q;
    wait_d       = '0;
    instret_d    = instret_q;
    fault_code_d = fault_code_q;
    unique case (state_q)
      // Reset-release cycle is quiet; the following BOOT cycle carries the PC-zero pulse.
      S_BOOT:   if (update_pc_q) state_d = S_FETCH;
      S_FETCH: begin
        if (bus.imem_ready) begin
          state_d = S_DECODE;
        end else if (wait_q == CW'(MEM_TIMEOUT - 1)) begin
          state_d      = S_FAULT;
          fault_code_d = FC_IMEM_TO;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      S_DECODE: begin
        if (is_legal_c) begin
          state_d = S_EXEC;
        end else begin
          state_d      = S_FAULT;
          fault_code_d = FC_ILLEGAL;
        end
      end
      S_EXEC:   state_d = is_ldst_c ? S_MEM : S_WB;
      S_MEM: begin
        if (bus.dmem_ready) begin
          state_d = S_WB;
        end else if (wait_q == CW'(MEM_TIMEOUT - 1)) begin
          state_d      = S_FAULT;
          fault_code_d = FC_DMEM_TO;
        end else begin
          wait_d = wait_q + CW'(1);
        end
      end
      S_WB: begin
        instret_d = instret_q + DATA_WIDTH'(1);
        state_d   = bus.halt_req ? S_HALT : S_FETCH;
      end
      S_HALT:   if (!bus.halt_req) state_d = S_FETCH;
      S_FAULT:  state_d = S_FAULT;
      default:  state_d = S_FAULT;
    endcase
  end

  // Moore outputs decoded from the upcoming state so they register in step with it.
  always_comb begin
    boot_pulse_c   = (state_q == S_BOOT) && (state_d == S_BOOT);
    imem_req_d     = (state_d == S_FETCH);
    dmem_req_d     = (state_d == S_MEM);
    dmem_we_d      = (state_d == S_MEM) && is_store_c;
    reg_write_en_d = (state_d == S_WB) && writes_rd_c;
    update_pc_d    = (state_d == S_WB) || boot_pulse_c;
    pc_zero_d      = boot_pulse_c;
    halted_d       = (state_d == S_HALT);
    fault_d        = (state_d == S_FAULT);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_BOOT;
      wait_q         <= '0;
      instret_q      <= '0;
      fault_code_q   <= '0;
      imem_req_q     <= 1'b0;
      dmem_req_q     <= 1'b0;
      dmem_we_q      <= 1'b0;
      reg_write_en_q <= 1'b0;
      update_pc_q    <= 1'b0;
      pc_zero_q      <= 1'b0;
      halted_q       <= 1'b0;
      fault_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      wait_q         <= wait_d;
      instret_q      <= instret_d;
      fault_code_q   <= fault_code_d;
      imem_req_q     <= imem_req_d;
      dmem_req_q     <= dmem_req_d;
      dmem_we_q      <= dmem_we_d;
      reg_write_en_q <= reg_write_en_d;
      update_pc_q    <= update_pc_d;
      pc_zero_q      <= pc_zero_d;
      halted_q       <= halted_d;
      fault_q        <= fault_d;
    end
  end

  // ir_load is the one combinational output: capture on the cycle fetch data is valid.
  assign bus.ir_load      = (state_q == S_FETCH) && bus.imem_ready;
  assign bus.imem_req     = imem_req_q;
  assign bus.dmem_req     = dmem_req_q;
  assign bus.dmem_we      = dmem_we_q;
  assign bus.reg_write_en = reg_write_en_q;
  assign bus.update_pc    = update_pc_q;
  assign bus.pc_zero      = pc_zero_q;
  assign bus.halted       = halted_q;
  assign bus.fault        = fault_q;
  assign bus.fault_code   = fault_code_q;
  assign bus.instret      = instret_q;

endmodule
